// File: rtl/serial2parallel_fr.sv
// serial2parallel_fr: framed N-bit deserialiser with bit order select, continuous framing, valid/ready output and sticky overrun; in clk rst start d continuous word_ready clr_overrun, out word word_valid busy frame_start bit_cnt overrun
module serial2parallel_fr #(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             d,
  input  logic             continuous,
  output logic [N-1:0]     word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             frame_start,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             clr_overrun
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [N-1:0] sr, sr_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic done, load, drop, valid_nx, ovr_nx;
  always_comb begin
    frame_start = state == IDLE && start;
    busy = frame_start || state == SHIFT;
    done = busy && bit_cnt == CNT_W'(N - 1);
    sr_nx = MSB_FIRST ? {sr[N-2:0], d} : {d, sr[N-1:1]};
    cnt_nx = done ? '0 : bit_cnt + CNT_W'(1);
    state_nx = state == IDLE ? (start ? SHIFT : IDLE) : (done && !continuous ? IDLE : SHIFT);
    load = done && (!word_valid || word_ready);
    drop = done && word_valid && !word_ready;
    valid_nx = load || (word_valid && !word_ready);
    ovr_nx = drop || (overrun && !clr_overrun);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      word <= '0;
      word_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (busy) begin
        sr <= sr_nx;
        bit_cnt <= cnt_nx;
      end
      if (load) word <= sr_nx;
      word_valid <= valid_nx;
      overrun <= ovr_nx;
    end
  end
endmodule

// File: tb/tb_serial2parallel_fr.sv
// tb_serial2parallel_fr: directed and randomized checks of three serial2parallel_fr configurations against a bit-list reference model
module tb_serial2parallel_fr;
  logic clk = 1'b0;
  logic rst, start, d, continuous, word_ready, clr_overrun;
  logic [7:0] w0, w1;
  logic [11:0] w2;
  logic [2:0] c0, c1;
  logic [3:0] c2;
  logic v0, v1, v2, b0, b1, b2, f0, f1, f2, o0, o1, o2;
  logic [31:0] ow[3], oc[3];
  logic ov[3], ob[3], of[3], oo[3];
  int tests = 0;
  int fails = 0;
  int n[3] = '{8, 8, 12};
  bit msb[3] = '{1'b1, 1'b0, 1'b1};
  bit m_act[3], m_valid[3], m_ovr[3];
  int m_cnt[3];
  logic [31:0] m_bits[3], m_word[3];
  typedef struct {
    bit st;
    bit d;
    bit rdy;
    bit busy;
    bit vld;
    logic [7:0] w;
  } vec_t;
  vec_t tv[10];
  always #5 clk = ~clk;
  serial2parallel_fr #(.N(8), .MSB_FIRST(1'b1)) u_m8 (
    .clk(clk), .rst(rst), .start(start), .d(d), .continuous(continuous),
    .word(w0), .word_valid(v0), .word_ready(word_ready), .busy(b0),
    .frame_start(f0), .bit_cnt(c0), .overrun(o0), .clr_overrun(clr_overrun));
  serial2parallel_fr #(.N(8), .MSB_FIRST(1'b0)) u_l8 (
    .clk(clk), .rst(rst), .start(start), .d(d), .continuous(continuous),
    .word(w1), .word_valid(v1), .word_ready(word_ready), .busy(b1),
    .frame_start(f1), .bit_cnt(c1), .overrun(o1), .clr_overrun(clr_overrun));
  serial2parallel_fr #(.N(12), .MSB_FIRST(1'b1)) u_m12 (
    .clk(clk), .rst(rst), .start(start), .d(d), .continuous(continuous),
    .word(w2), .word_valid(v2), .word_ready(word_ready), .busy(b2),
    .frame_start(f2), .bit_cnt(c2), .overrun(o2), .clr_overrun(clr_overrun));
  always_comb begin
    ow[0] = {24'b0, w0};
    ow[1] = {24'b0, w1};
    ow[2] = {20'b0, w2};
    oc[0] = {29'b0, c0};
    oc[1] = {29'b0, c1};
    oc[2] = {28'b0, c2};
    ov = '{v0, v1, v2};
    ob = '{b0, b1, b2};
    of = '{f0, f1, f2};
    oo = '{o0, o1, o2};
  end
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] at %0t: got %h want %h", nm, k, $time, act, exp);
    end
  endtask
  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      chk("busy", k, 32'(ob[k]), 32'(m_act[k] | start));
      chk("frame_start", k, 32'(of[k]), 32'(!m_act[k] & start));
      chk("bit_cnt", k, oc[k], m_cnt[k]);
      chk("word", k, ow[k], m_word[k]);
      chk("word_valid", k, 32'(ov[k]), 32'(m_valid[k]));
      chk("overrun", k, 32'(oo[k]), 32'(m_ovr[k]));
    end
  endtask
  task automatic upd();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_act[k] = 0; m_cnt[k] = 0; m_bits[k] = '0; m_word[k] = '0; m_valid[k] = 0; m_ovr[k] = 0;
      end else begin
        bit comp, drop;
        logic [31:0] w;
        comp = 0; drop = 0; w = '0;
        if (m_act[k] | start) begin
          m_bits[k][m_cnt[k]] = d;
          m_cnt[k]++;
          if (m_cnt[k] == n[k]) begin
            comp = 1; m_cnt[k] = 0; m_act[k] = continuous;
          end else m_act[k] = 1;
        end
        if (comp) begin
          for (int i = 0; i < n[k]; i++)
            if (msb[k]) w[n[k]-1-i] = m_bits[k][i];
            else w[i] = m_bits[k][i];
          if (!m_valid[k] || word_ready) begin
            m_word[k] = w; m_valid[k] = 1;
          end else drop = 1;
        end else if (m_valid[k] && word_ready) m_valid[k] = 0;
        if (drop) m_ovr[k] = 1;
        else if (clr_overrun) m_ovr[k] = 0;
      end
    end
  endtask
  task automatic tick();
    #1 check_model();
    @(posedge clk);
    upd();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1; start = 0; d = 0; clr_overrun = 0;
    tick();
    rst = 0;
  endtask
  task automatic send8(input logic [7:0] v, input bit rdy_last);
    for (int i = 0; i < 8; i++) begin
      start = i == 0; d = v[7-i];
      word_ready = rdy_last && i == 7;
      tick();
    end
    start = 0;
  endtask
  initial begin
    logic [7:0] bits;
    logic [23:0] s;
    rst = 1; start = 0; d = 0; continuous = 0; word_ready = 1; clr_overrun = 0;
    @(posedge clk);
    upd();
    @(negedge clk);
    rst = 0;
    bits = 8'hA5;
    for (int i = 0; i < 10; i++)
      tv[i] = '{st: i == 0, d: i < 8 ? bits[7-i] : 1'b0, rdy: 1'b1,
                busy: i < 8, vld: i == 8, w: i < 8 ? 8'h00 : 8'hA5};
    for (int i = 0; i < 10; i++) begin
      start = tv[i].st; d = tv[i].d; word_ready = tv[i].rdy;
      #1;
      chk("tv_busy", i, 32'(b0), 32'(tv[i].busy));
      chk("tv_valid", i, 32'(v0), 32'(tv[i].vld));
      chk("tv_word_m", i, 32'(w0), 32'(tv[i].w));
      chk("tv_word_l", i, 32'(w1), 32'(tv[i].w));
      tick();
    end
    do_reset();
    word_ready = 1;
    send8(8'b1100_0000, 1'b1);
    #1 chk("lsb_word", 1, ow[1], 32'h03);
    chk("lsb_msbword", 0, ow[0], 32'hC0);
    tick();
    do_reset();
    continuous = 1; word_ready = 1;
    s = 24'hABC123;
    for (int i = 0; i < 24; i++) begin
      start = i == 0; d = s[23-i];
      if (i == 12) begin
        #1 chk("cont_w0", 2, ow[2], 32'hABC);
        chk("cont_v0", 2, 32'(v2), 1);
      end
      if (i > 0) chk("cont_fs", i, 32'(f2), 0);
      tick();
    end
    start = 0;
    #1 chk("cont_w1", 2, ow[2], 32'h123);
    chk("cont_v1", 2, 32'(v2), 1);
    tick();
    continuous = 0;
    do_reset();
    word_ready = 0;
    send8(8'h11, 1'b0);
    send8(8'h22, 1'b0);
    #1 chk("ovr_word", 0, ow[0], 32'h11);
    chk("ovr_flag", 0, 32'(o0), 1);
    clr_overrun = 1; word_ready = 1;
    tick();
    clr_overrun = 0; word_ready = 0;
    #1 chk("ovr_clr", 0, 32'(o0), 0);
    chk("ovr_vclr", 0, 32'(v0), 0);
    tick();
    do_reset();
    word_ready = 0;
    send8(8'h11, 1'b0);
    send8(8'h22, 1'b1);
    word_ready = 0;
    #1 chk("coin_word", 0, ow[0], 32'h22);
    chk("coin_valid", 0, 32'(v0), 1);
    chk("coin_ovr", 0, 32'(o0), 0);
    tick();
    do_reset();
    word_ready = 1;
    for (int i = 0; i < 4; i++) begin
      start = i == 0; d = 1;
      tick();
    end
    start = 0;
    #1 chk("mid_cnt", 0, oc[0], 4);
    rst = 1;
    tick();
    rst = 0; d = 0;
    #1 chk("rst_word", 0, ow[0], 0);
    chk("rst_valid", 0, 32'(v0), 0);
    chk("rst_busy", 0, 32'(b0), 0);
    chk("rst_cnt", 0, oc[0], 0);
    chk("rst_ovr", 0, 32'(o0), 0);
    send8(8'h5A, 1'b1);
    #1 chk("post_rst_word", 0, ow[0], 32'h5A);
    chk("post_rst_valid", 0, 32'(v0), 1);
    tick();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      start = $urandom_range(0, 3) == 0;
      d = 1'($urandom);
      word_ready = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 49) == 0) continuous = ~continuous;
      clr_overrun = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 199) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial2parallel_fr.md
# serial2parallel_fr

Parametrised serial-to-parallel deserialiser with framed capture, selectable bit order, optional back-to-back framing, and a valid/ready output register with overrun detection. It sits between a 1-bit serial input stream (e.g. key or data bits shifted in from pins) and word-wide consumers such as the cipher datapath. It generalises the team's 8-bit fixed deserialiser to any width `N`. Unlike that block, it holds each completed word until the consumer accepts it.

## Interface
- `N`, 8, word width in bits; legal range 2..32.
- `MSB_FIRST`, 1, 1: first serial bit lands in `word[N-1]`; 0: first bit lands in `word[0]`.
- `CNT_W`, `$clog2(N)`, bit-counter width; derived, do not override.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  frame start; `d` is the first bit of the frame in the same cycle.
- `d`  in  1  serial data, sampled every cycle while shifting.
- `continuous`  in  1  1: the next frame begins immediately after bit N-1, without a new `start`.
- `word`  out  N  completed word; valid when `word_valid`=1.
- `word_valid`  out  1  output register holds an unconsumed word.
- `word_ready`  in  1  consumer accepts `word` when `word_valid`&`word_ready`.
- `busy`  out  1  combinational: `(state==IDLE & start) | state==SHIFT`.
- `frame_start`  out  1  combinational: `state==IDLE & start`.
- `bit_cnt`  out  CNT_W  number of bits captured in the current frame (0..N-1).
- `overrun`  out  1  sticky: a completed word was dropped.
- `clr_overrun`  in  1  clears `overrun`.

## Operation
- States: IDLE, SHIFT. Reset values: state IDLE, shift reg 0, `bit_cnt` 0, `word` 0, `word_valid` 0, `overrun` 0.
- Sampling rule: a bit is sampled in a cycle exactly when `busy`=1.
  - MSB_FIRST=1: `sr <= {sr[N-2:0], d}`.
  - MSB_FIRST=0: `sr <= {d, sr[N-1:1]}`.
- Counter: `bit_cnt` increments on each sampled bit and wraps from N-1 to 0 when a frame completes.
- Transitions:
  - IDLE→SHIFT when `start`=1.
  - SHIFT→IDLE on the completing sample (`bit_cnt`==N-1) if `continuous`=0.
  - SHIFT→SHIFT if `continuous`=1.
  - `start` during SHIFT is ignored; it does not restart the frame.
- Completion: the cycle where a bit is sampled with `bit_cnt`==N-1. The completed word is `sr` with `d` shifted in.
- Output register:
  - On completion, if `word_valid`=0 or `word_ready`=1: load `word`; `word_valid` becomes 1.
  - On completion, if `word_valid`=1 and `word_ready`=0: the new word is dropped, `overrun` is set, and `word` is unchanged.
  - With no completion, `word_valid` clears on `word_valid & word_ready`.
  - `word` remains stable while `word_valid` is high and not accepted.
- `overrun`: set on drop, cleared by `clr_overrun`; set wins when both occur in the same cycle.
- Reset mid-frame discards the partial word and any held word; all outputs return to reset values the next cycle.

## Timing
- Frame started at cycle 0 (with `start`=1 and bit 0 on `d`): bits are sampled in cycles 0..N-1.
- `word_valid` rises at cycle N (registered), giving N-cycle latency from `start` to `word_valid`.
- `busy` is high in cycles 0..N-1. With `continuous`=0 it drops at cycle N unless `start` is high then.
- Back-to-back, `continuous`=0: `start` at cycle N is accepted, with no dead cycle.
- `continuous`=1: frame k completes at cycle N·(k+1)-1, and its word is valid at N·(k+1).
- Consumer handshake: with `word_ready` tied high, each word is visible for exactly 1 cycle.

## Test plan
- N=8, MSB_FIRST=1: `start`, then serial 1,0,1,0,0,1,0,1 with `word_ready`=1 → `word`=0xA5 and `word_valid` for 1 cycle at cycle 8; `busy` high for cycles 0..7.
- N=8, MSB_FIRST=0, same bits → `word`=0xA5 bit-reversed = 0xA5 (palindrome); then repeat with 1,1,0,0,0,0,0,0 → `word`=0x03.
- N=12, `continuous`=1, `word_ready`=1, streaming 0xABC then 0x123 MSB-first → `word_valid` at cycles 12 and 24 with 0xABC and 0x123; `frame_start` only at cycle 0.
- N=8, `word_ready`=0: send 0x11 then 0x22 → `word` stays 0x11, `overrun`=1 at cycle 16. Assert `clr_overrun` and `word_ready` → `overrun`=0 and `word_valid`=0 the next cycle.
- Completion coincides with acceptance (`word_valid`=1 holding 0x11, `word_ready`=1 at the completion of 0x22) → `word`=0x22, `word_valid` stays 1, `overrun` stays 0.
- `rst` asserted at `bit_cnt`=4, then a new frame 0x5A → 0x5A is captured correctly with no residue; all outputs are zero in the cycle after `rst`.
